// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline hazard / stall sequencer for the 5-stage MIPS core. Detects
//   load-use hazards on EX operands, freezes the pipe for the fixed-latency
//   mul/div unit, flushes IF/ID and ID/EX on taken branches and holds the
//   core on a WB-stage syscall halt. Events are arbitrated by fixed priority:
//   halt > load-use > mul/div issue > branch.
//
//   Freeze locks PC, IF/ID and ID/EX and loads a bubble into EX/MEM; the four
//   freeze outputs always move together. Flushes never co-assert with freeze.
//
// Parameters
//   REG_W  - register-number width (register 0 is never a hazard)
//   MD_LAT - total EX stall cycles per mul/div issue (1..255)
//   CNT_W  - width of the mul/div countdown counter
//
// Ports
//   clk, rst                  - clock (rising edge), async active-high reset
//   ex_rs_num/ex_rt_num       - EX source register numbers
//   ex_rs_used/ex_rt_used     - EX instruction reads rs / rt
//   mem_wr_num, mem_load      - MEM destination register, MEM is a load
//   md_start                  - EX issues a mul/div
//   branch_taken              - taken branch/jump resolved in EX
//   halt_req, resume          - WB syscall halt, single-cycle release pulse
//   pc_stall, ifid_stall,
//   idex_stall, exmem_clear   - freeze group
//   ifid_flush, idex_flush    - branch flush
//   halted, md_busy           - in HALTED / in MD_WAIT
//
// Optional feature (macro HAZARD_STAT_EN): adds 32-bit wrap-around counters
//   stat_lu_cycles, stat_md_cycles and stat_flushes as extra outputs.

module hazard_stall_ctrl #(
    parameter int REG_W  = 7,
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] ex_rs_num,
    input  logic [REG_W-1:0] ex_rt_num,
    input  logic             ex_rs_used,
    input  logic             ex_rt_used,
    input  logic [REG_W-1:0] mem_wr_num,
    input  logic             mem_load,
    input  logic             md_start,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             resume,
`ifdef HAZARD_STAT_EN
    output logic [31:0]      stat_lu_cycles,
    output logic [31:0]      stat_md_cycles,
    output logic [31:0]      stat_flushes,
`endif
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_clear,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             md_busy
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        HALTED  = 2'd2
    } state_e;

    // Counter is loaded with MD_LAT-1 on issue: the issue cycle itself is the
    // first of the MD_LAT frozen cycles.
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lu;
    logic freeze, flush, halted_c, busy_c;

    assign lu = mem_load && (mem_wr_num != '0) &&
                ((ex_rs_used && (ex_rs_num == mem_wr_num)) ||
                 (ex_rt_used && (ex_rt_num == mem_wr_num)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freeze   = 1'b0;
        flush    = 1'b0;
        halted_c = 1'b0;
        busy_c   = 1'b0;
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    freeze  = 1'b1;
                    state_d = HALTED;
                end else if (lu) begin
                    freeze = 1'b1;
                end else if (md_start) begin
                    freeze  = 1'b1;
                    cnt_d   = MD_LOAD;
                    state_d = MD_WAIT;
                end else if (branch_taken) begin
                    flush = 1'b1;
                end
            end
            MD_WAIT: begin
                busy_c = 1'b1;
                if (cnt_q != '0) begin
                    freeze = 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                freeze   = 1'b1;
                halted_c = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // RUN outputs are Mealy, so rst must gate them to keep outputs at 0
    // while reset is held regardless of the event inputs.
    assign pc_stall    = freeze   & ~rst;
    assign ifid_stall  = freeze   & ~rst;
    assign idex_stall  = freeze   & ~rst;
    assign exmem_clear = freeze   & ~rst;
    assign ifid_flush  = flush    & ~rst;
    assign idex_flush  = flush    & ~rst;
    assign halted      = halted_c & ~rst;
    assign md_busy     = busy_c   & ~rst;

`ifdef HAZARD_STAT_EN
    logic        lu_stall, md_freeze;
    logic [31:0] stat_lu_q, stat_md_q, stat_fl_q;

    assign lu_stall  = (state_q == RUN) && !halt_req && lu;
    assign md_freeze = ((state_q == RUN) && !halt_req && !lu && md_start) ||
                       ((state_q == MD_WAIT) && (cnt_q != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lu_q <= '0;
            stat_md_q <= '0;
            stat_fl_q <= '0;
        end else begin
            if (lu_stall)  stat_lu_q <= stat_lu_q + 32'd1;
            if (md_freeze) stat_md_q <= stat_md_q + 32'd1;
            if (flush)     stat_fl_q <= stat_fl_q + 32'd1;
        end
    end

    assign stat_lu_cycles = stat_lu_q;
    assign stat_md_cycles = stat_md_q;
    assign stat_flushes   = stat_fl_q;
`endif

endmodule
